// File: rtl/maxpool2x2_stream.sv
// ---------------------------------------------------------------------------
// maxpool2x2_stream
//
// Streaming 2x2 / stride-2 max-pooling stage for one feature-map channel.
// Pixels arrive in raster order (row-major, column fastest) with no
// backpressure. Each even/odd column pair is reduced horizontally. On even
// rows the horizontal max is parked in a half-width line buffer. On odd rows
// it is combined with the parked value to form one pooled pixel.
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   start      single-cycle pulse, arms the block for one frame (IDLE only)
//   in_valid   in_data carries a pixel this cycle
//   in_data    signed input pixel, raster order
//   out_valid  single-cycle pulse per pooled pixel
//   out_data   signed pooled pixel, holds its value between pulses
//   pool_done  single-cycle pulse with the last out_valid of the frame
//   busy       high from the cycle after start through the pool_done cycle
// ---------------------------------------------------------------------------
module maxpool2x2_stream #(
    parameter int DATA_W = 16,
    parameter int IMG_W  = 24,
    parameter int IMG_H  = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     pool_done,
    output logic                     busy
);

    localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LB_N   = IMG_W / 2;
    localparam int LB_AW  = (LB_N > 1) ? $clog2(LB_N) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                    state_q, state_d;
    logic [COL_W-1:0]          col_q, col_d;
    logic [ROW_W-1:0]          row_q, row_d;
    logic signed [DATA_W-1:0]  h_reg_q, h_reg_d;
    logic                      out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0]  out_data_q, out_data_d;

    // Line buffer: one horizontal max per column pair of the previous even row.
    logic signed [DATA_W-1:0]  linebuf_q [LB_N];

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic                      accept;
    logic                      last_col;
    logic                      last_row;
    logic [LB_AW-1:0]          lb_addr;
    logic signed [DATA_W-1:0]  lb_rdata;
    logic signed [DATA_W-1:0]  hmax;
    logic signed [DATA_W-1:0]  vmax;
    logic                      lb_we;

    assign accept   = (state_q == S_RUN) && in_valid;
    assign last_col = (col_q == COL_W'(IMG_W - 1));
    assign last_row = (row_q == ROW_W'(IMG_H - 1));
    assign lb_addr  = LB_AW'(col_q >> 1);
    assign lb_rdata = linebuf_q[lb_addr];

    // Both operands are declared signed, so the compare is two's complement.
    // Ties fall through to the second operand; the value is identical.
    assign hmax = (h_reg_q > in_data) ? h_reg_q : in_data;
    assign vmax = (lb_rdata > hmax)   ? lb_rdata : hmax;

    // ------------------------------------------------------------------
    // Next-state / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        h_reg_d     = h_reg_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        lb_we       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end

            S_RUN: begin
                if (accept) begin
                    if (!col_q[0]) begin
                        h_reg_d = in_data;
                    end else if (!row_q[0]) begin
                        lb_we = 1'b1;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = vmax;
                    end

                    if (last_col) begin
                        col_d = '0;
                        if (last_row) begin
                            row_d   = '0;
                            state_d = S_FLUSH;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end

            // The final pooled pixel is on out_valid during this cycle;
            // in_valid and start are both ignored here.
            S_FLUSH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            h_reg_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            h_reg_q     <= h_reg_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // NOTE: the line buffer is deliberately not reset. Every entry is written
    // on an even row before it is read on the following odd row, and leaving
    // it reset-free lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            linebuf_q[lb_addr] <= hmax;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign pool_done = (state_q == S_FLUSH);
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// ---------------------------------------------------------------------------
// tb_maxpool2x2_stream
//
// Two instances: a 4x4 one for the directed frames and a default 24x24 one
// for back-to-back random frames. Expected pooled pixels are computed from
// the stimulus frame and queued when the completing odd/odd pixel is driven,
// together with the negedge count at which the output must appear.
// ---------------------------------------------------------------------------
module tb_maxpool2x2_stream;

    localparam int DW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 4x4 instance
    logic                 s4_start    = 1'b0;
    logic                 s4_in_valid = 1'b0;
    logic signed [DW-1:0] s4_in_data  = '0;
    logic                 s4_out_valid, s4_pool_done, s4_busy;
    logic signed [DW-1:0] s4_out_data;

    // 24x24 instance
    logic                 s24_start    = 1'b0;
    logic                 s24_in_valid = 1'b0;
    logic signed [DW-1:0] s24_in_data  = '0;
    logic                 s24_out_valid, s24_pool_done, s24_busy;
    logic signed [DW-1:0] s24_out_data;

    maxpool2x2_stream #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (s4_start),
        .in_valid  (s4_in_valid),
        .in_data   (s4_in_data),
        .out_valid (s4_out_valid),
        .out_data  (s4_out_data),
        .pool_done (s4_pool_done),
        .busy      (s4_busy)
    );

    maxpool2x2_stream #(.DATA_W(DW)) u_dut24 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (s24_start),
        .in_valid  (s24_in_valid),
        .in_data   (s24_in_data),
        .out_valid (s24_out_valid),
        .out_data  (s24_out_data),
        .pool_done (s24_pool_done),
        .busy      (s24_busy)
    );

    typedef struct {
        logic signed [DW-1:0] data;
        bit                   last;
        int                   due;
    } exp_t;

    exp_t q4[$];
    exp_t q24[$];

    int tests      = 0;
    int fails      = 0;
    int neg_cnt    = 0;
    int done4_cnt  = 0;
    int done24_cnt = 0;
    int out24_cnt  = 0;

    logic signed [DW-1:0] f4  [16];
    logic signed [DW-1:0] f24 [576];

    function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Window whose bottom-right pixel is (r, c) in the 4x4 frame.
    function automatic logic signed [DW-1:0] win4(input int r, input int c);
        return smax(smax(f4[(r-1)*4 + c-1], f4[(r-1)*4 + c]),
                    smax(f4[r*4 + c-1],     f4[r*4 + c]));
    endfunction

    function automatic logic signed [DW-1:0] win24(input int r, input int c);
        return smax(smax(f24[(r-1)*24 + c-1], f24[(r-1)*24 + c]),
                    smax(f24[r*24 + c-1],     f24[r*24 + c]));
    endfunction

    // ------------------------------------------------------------------
    // Output monitor / scoreboard (sampled on the falling edge)
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        exp_t e;
        neg_cnt++;

        if (s4_pool_done) done4_cnt++;
        if (s4_out_valid) begin
            tests++;
            if (q4.size() == 0) begin
                fails++;
                $display("FAIL mon4_unexpected: out_valid=1 data=%0d, expected no output", s4_out_data);
            end else begin
                e = q4.pop_front();
                if (s4_out_data !== e.data) begin
                    fails++;
                    $display("FAIL mon4_data: got %0d, expected %0d", s4_out_data, e.data);
                end
                tests++;
                if (neg_cnt !== e.due) begin
                    fails++;
                    $display("FAIL mon4_latency: output at cycle %0d, expected cycle %0d", neg_cnt, e.due);
                end
                tests++;
                if (s4_pool_done !== e.last) begin
                    fails++;
                    $display("FAIL mon4_pool_done: got %0b, expected %0b", s4_pool_done, e.last);
                end
            end
        end else if (s4_pool_done) begin
            tests++;
            fails++;
            $display("FAIL mon4_done_alone: pool_done=1 with out_valid=0, expected 0");
        end

        if (s24_pool_done) done24_cnt++;
        if (s24_out_valid) begin
            out24_cnt++;
            tests++;
            if (q24.size() == 0) begin
                fails++;
                $display("FAIL mon24_unexpected: out_valid=1 data=%0d, expected no output", s24_out_data);
            end else begin
                e = q24.pop_front();
                if (s24_out_data !== e.data) begin
                    fails++;
                    $display("FAIL mon24_data: got %0d, expected %0d", s24_out_data, e.data);
                end
                tests++;
                if (neg_cnt !== e.due) begin
                    fails++;
                    $display("FAIL mon24_latency: output at cycle %0d, expected cycle %0d", neg_cnt, e.due);
                end
                tests++;
                if (s24_pool_done !== e.last) begin
                    fails++;
                    $display("FAIL mon24_pool_done: got %0b, expected %0b", s24_pool_done, e.last);
                end
            end
        end else if (s24_pool_done) begin
            tests++;
            fails++;
            $display("FAIL mon24_done_alone: pool_done=1 with out_valid=0, expected 0");
        end
    end

    // ------------------------------------------------------------------
    // Drivers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic start4();
        @(posedge clk); #1;
        s4_in_valid = 1'b0;
        tests++;
        if (s4_busy !== 1'b0) begin
            fails++;
            $display("FAIL busy4_idle: got %0b, expected 0", s4_busy);
        end
        s4_start = 1'b1;
        @(posedge clk); #1;
        s4_start = 1'b0;
        tests++;
        if (s4_busy !== 1'b1) begin
            fails++;
            $display("FAIL busy4_after_start: got %0b, expected 1", s4_busy);
        end
    endtask

    // Drives pixels f4[first..last_idx]; gap idle cycles with garbage data
    // precede each pixel. Optionally re-pulses start in the middle.
    task automatic pix4(input int first, input int last_idx, input int gap,
                        input bit restart_mid);
        for (int i = first; i <= last_idx; i++) begin
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                s4_in_valid = 1'b0;
                s4_in_data  = DW'($urandom);
                s4_start    = 1'b0;
            end
            @(posedge clk); #1;
            s4_in_valid = 1'b1;
            s4_in_data  = f4[i];
            s4_start    = (restart_mid && i == 8);
            if (((i / 4) % 2 == 1) && ((i % 4) % 2 == 1))
                q4.push_back('{data: win4(i / 4, i % 4), last: (i == 15), due: neg_cnt + 2});
        end
    endtask

    // Completes a frame after pixel 15 and checks the FLUSH cycle.
    task automatic flush4();
        @(posedge clk); #1;
        s4_start    = 1'b0;
        s4_in_valid = 1'b1;                 // ignored: frame already complete
        s4_in_data  = DW'($urandom);
        tests++;
        if (s4_pool_done !== 1'b1) begin
            fails++;
            $display("FAIL flush4_pool_done: got %0b, expected 1", s4_pool_done);
        end
        tests++;
        if (s4_busy !== 1'b1) begin
            fails++;
            $display("FAIL flush4_busy: got %0b, expected 1", s4_busy);
        end
        @(negedge clk); #1;
        tests++;
        if (q4.size() != 0) begin
            fails++;
            $display("FAIL flush4_missing: %0d outputs outstanding, expected 0", q4.size());
        end
    endtask

    task automatic ramp4();
        for (int i = 0; i < 16; i++) f4[i] = DW'(i);
    endtask

    task automatic start24();
        @(posedge clk); #1;
        s24_in_valid = 1'b0;
        tests++;
        if (s24_busy !== 1'b0) begin
            fails++;
            $display("FAIL busy24_idle: got %0b, expected 0", s24_busy);
        end
        s24_start = 1'b1;
        @(posedge clk); #1;
        s24_start = 1'b0;
    endtask

    task automatic frame24();
        for (int i = 0; i < 576; i++) begin
            @(posedge clk); #1;
            s24_in_valid = 1'b1;
            s24_in_data  = f24[i];
            if (((i / 24) % 2 == 1) && ((i % 24) % 2 == 1))
                q24.push_back('{data: win24(i / 24, i % 24), last: (i == 575), due: neg_cnt + 2});
        end
        @(posedge clk); #1;
        s24_in_valid = 1'b0;
        tests++;
        if (s24_pool_done !== 1'b1) begin
            fails++;
            $display("FAIL flush24_pool_done: got %0b, expected 1", s24_pool_done);
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        #1;
        tests++;
        if ({s4_out_valid, s4_pool_done, s4_busy} !== 3'b000) begin
            fails++;
            $display("FAIL reset_ctrl4: got %b, expected 000", {s4_out_valid, s4_pool_done, s4_busy});
        end
        tests++;
        if (s4_out_data !== '0) begin
            fails++;
            $display("FAIL reset_data4: got %0d, expected 0", s4_out_data);
        end
        tests++;
        if ({s24_out_valid, s24_pool_done, s24_busy, s24_out_data} !== '0) begin
            fails++;
            $display("FAIL reset_24: got %b/%0d, expected 000/0",
                     {s24_out_valid, s24_pool_done, s24_busy}, s24_out_data);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (s4_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_busy: got %0b, expected 0", s4_busy);
        end
    endtask

    task automatic test_ramp();
        ramp4();
        start4();
        pix4(0, 15, 0, 1'b0);
        flush4();
    endtask

    task automatic test_signed_corners();
        for (int i = 0; i < 16; i++) f4[i] = -16'sd3;
        f4[0]  = -16'sd1;   // window 0, top-left
        f4[3]  = -16'sd1;   // window 1, top-right
        f4[12] = -16'sd1;   // window 2, bottom-left
        f4[15] = -16'sd1;   // window 3, bottom-right
        start4();
        pix4(0, 15, 0, 1'b0);
        flush4();
        tests++;
        if (s4_out_data !== -16'sd1) begin
            fails++;
            $display("FAIL signed_last_value: got %0d, expected -1", s4_out_data);
        end
    endtask

    task automatic test_gaps();
        ramp4();
        start4();
        pix4(0, 15, 2, 1'b0);
        flush4();
        // out_data must hold the last pooled value while idle
        tests++;
        if (s4_out_data !== 16'sd15) begin
            fails++;
            $display("FAIL gaps_hold: got %0d, expected 15", s4_out_data);
        end
    endtask

    task automatic test_prestart_and_restart();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            s4_in_valid = 1'b1;
            s4_in_data  = 16'sd100;
        end
        @(posedge clk); #1;
        s4_in_valid = 1'b0;
        tests++;
        if (s4_busy !== 1'b0) begin
            fails++;
            $display("FAIL prestart_busy: got %0b, expected 0", s4_busy);
        end
        ramp4();
        start4();
        pix4(0, 15, 0, 1'b1);
        flush4();
    endtask

    task automatic test_reset_midframe();
        int done_before;
        ramp4();
        start4();
        pix4(0, 5, 0, 1'b0);
        @(posedge clk); #1;
        s4_in_valid = 1'b0;
        @(posedge clk); #1;
        done_before = done4_cnt;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({s4_out_valid, s4_pool_done, s4_busy} !== 3'b000) begin
            fails++;
            $display("FAIL midreset_ctrl: got %b, expected 000", {s4_out_valid, s4_pool_done, s4_busy});
        end
        tests++;
        if (s4_out_data !== '0) begin
            fails++;
            $display("FAIL midreset_data: got %0d, expected 0", s4_out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (s4_busy !== 1'b0 || done4_cnt !== done_before) begin
            fails++;
            $display("FAIL midreset_no_done: busy=%0b done_pulses=%0d, expected 0 and %0d",
                     s4_busy, done4_cnt - done_before, 0);
        end
        tests++;
        if (q4.size() != 0) begin
            fails++;
            $display("FAIL midreset_pending: %0d outputs outstanding, expected 0", q4.size());
        end
        start4();
        pix4(0, 15, 0, 1'b0);
        flush4();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 576; i++) begin
            int v;
            v = int'($urandom_range(40000)) - 20000;
            f24[i] = DW'(v);
        end
        start24();
        frame24();
        for (int i = 0; i < 576; i++) f24[i] = -f24[i];
        start24();                          // the cycle after pool_done
        frame24();
        @(negedge clk); #1;
        tests++;
        if (q24.size() != 0) begin
            fails++;
            $display("FAIL b2b_missing: %0d outputs outstanding, expected 0", q24.size());
        end
        tests++;
        if (out24_cnt !== 288) begin
            fails++;
            $display("FAIL b2b_count: got %0d outputs, expected 288", out24_cnt);
        end
        tests++;
        if (done24_cnt !== 2) begin
            fails++;
            $display("FAIL b2b_done: got %0d pool_done pulses, expected 2", done24_cnt);
        end
        @(posedge clk); #1;
        tests++;
        if (s24_busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_busy_end: got %0b, expected 0", s24_busy);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_signed_corners();
        test_gaps();
        test_prestart_and_restart();
        test_reset_midframe();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
